fetch_prefetch_unit: RTL and testbench

- Parametrised instruction-fetch front end between the flash word port and the ControlUnit/Datapath instruction register.
- Issues flash read requests ahead of execution.
- Buffers returned words with their addresses in a DEPTH-entry FIFO.
- Flushes and redirects on branch.
- Replaces single-word fetch gated by ld_flash/busy_flA, removing fetch stalls on sequential code.

---
 rtl/fetch_prefetch_unit.sv | 74 +++++++
 tb/tb_fetch_prefetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: flash prefetcher feeding the instruction register through a DEPTH-entry FIFO,
// flushed and redirected on branch.
module fetch_prefetch_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    busy_fl,
  input  logic [DATA_W-1:0]       dout_flash,
  output logic                    ld_flash,
  output logic [ADDR_W-1:0]       flash_addr_PC,
  input  logic                    br_valid,
  input  logic [ADDR_W-1:0]       br_target,
  input  logic                    instr_ready,
  output logic                    instr_valid,
  output logic [DATA_W-1:0]       instr_out,
  output logic [ADDR_W-1:0]       instr_addr,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_HI = 2'd2, WAIT_LO = 2'd3;
  logic [1:0] state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic discard, pop, cap, push, start;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] mem_a [DEPTH];
  assign instr_valid = level != '0;
  assign instr_out = mem_d[rd_ptr];
  assign instr_addr = mem_a[rd_ptr];
  assign ld_flash = state == REQ;
  assign pop = instr_valid && instr_ready && !br_valid;
  assign cap = state == WAIT_LO && !busy_fl;
  assign push = cap && !discard && !br_valid;
  // only IDLE has nothing outstanding, so a free slot (or one freed this edge) is enough to fetch
  assign start = state == IDLE && !br_valid && !busy_fl && (level < FULL || pop);
  always_comb
    state_nxt = state == IDLE    ? (start ? REQ : IDLE) :
                state == REQ     ? WAIT_HI :
                state == WAIT_HI ? (busy_fl ? WAIT_LO : WAIT_HI) :
                                   (busy_fl ? WAIT_LO : IDLE);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      flash_addr_PC <= RESET_PC;
      discard <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_a[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (start) flash_addr_PC <= fetch_pc;
      fetch_pc <= br_valid ? br_target : fetch_pc + ADDR_W'(push);
      // a redirect with a request in flight poisons its response
      discard <= !cap && (discard || (br_valid && state != IDLE));
      if (push) begin
        mem_d[wr_ptr] <= dout_flash;
        mem_a[wr_ptr] <= fetch_pc;
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= br_valid ? wr_ptr : rd_ptr + PW'(pop);
      level <= br_valid ? '0 : level + (PW+1)'(push) - (PW+1)'(pop);
    end
  assert property (@(posedge clk) disable iff (!rst) !(push && level == FULL));
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: flash responder plus transaction-level model of the prefetch stream.
module tb_fetch_prefetch_unit;
  localparam int ADDR_W = 10, DATA_W = 32, DEPTH = 4;
  localparam logic [9:0] RESET_PC = 10'h000;
  logic clk = 0, rst = 0, busy_fl = 0, br_valid = 0, instr_ready = 0;
  logic [9:0] br_target = 0, flash_addr_PC, instr_addr;
  logic [31:0] dout_flash, instr_out;
  logic ld_flash, instr_valid;
  logic [2:0] level;
  int n_cmp = 0, n_err = 0, n_pop = 0;
  logic [9:0] reqs[$];
  int m_level = 0;
  logic [9:0] m_pc = 0, exp_addr = 0, ra = 0;
  logic pending = 0, seen_hi = 0, tainted = 0, pop, cap, rnd = 0;
  int hi_cfg = 2, pre_r = 0, hi_r = 2, pcnt = 0, hcnt = 0, ph = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] fdat(input logic [9:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign dout_flash = fdat(ra);

  fetch_prefetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .busy_fl(busy_fl), .dout_flash(dout_flash), .ld_flash(ld_flash),
    .flash_addr_PC(flash_addr_PC), .br_valid(br_valid), .br_target(br_target),
    .instr_ready(instr_ready), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_addr(instr_addr), .level(level)
  );

  // flash: optional idle delay after the strobe, then busy for hi cycles; data follows the latched address
  always @(posedge clk) begin
    pre_r <= rnd ? int'($urandom_range(0, 2)) : 0;
    hi_r <= rnd ? int'($urandom_range(1, 3)) : hi_cfg;
    if (ld_flash) begin
      ra <= flash_addr_PC;
      hcnt <= hi_r;
      pcnt <= pre_r;
      if (pre_r == 0) busy_fl <= 1'b1;
      ph <= (pre_r == 0) ? 2 : 1;
    end else if (ph == 1) begin
      if (pcnt == 1) begin busy_fl <= 1'b1; ph <= 2; end
      pcnt <= pcnt - 1;
    end else if (ph == 2) begin
      if (hcnt == 1) begin busy_fl <= 1'b0; ph <= 0; end
      hcnt <= hcnt - 1;
    end
  end

  // stream model: consumer sees consecutive addresses from the last redirect, each carrying fdat(addr)
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      m_level = 0; m_pc = RESET_PC; exp_addr = RESET_PC; pending = 0; seen_hi = 0; tainted = 0;
    end else begin
      n_cmp++;
      if (int'(level) !== m_level) begin
        n_err++; $display("FAIL level: got %0d want %0d at %0t", level, m_level, $time);
      end
      n_cmp++;
      if (instr_valid !== (m_level != 0)) begin
        n_err++; $display("FAIL instr_valid: got %0b want %0b at %0t", instr_valid, m_level != 0, $time);
      end
      if (ld_flash) begin
        n_cmp++;
        if (flash_addr_PC !== m_pc || m_level >= DEPTH || pending) begin
          n_err++;
          $display("FAIL request: addr %h want %h, level %0d, outstanding %0b at %0t",
                   flash_addr_PC, m_pc, m_level, pending, $time);
        end
        reqs.push_back(flash_addr_PC);
      end
      pop = instr_valid && instr_ready && !br_valid;
      if (pop) begin
        n_cmp++;
        if (instr_addr !== exp_addr || instr_out !== fdat(exp_addr)) begin
          n_err++;
          $display("FAIL pop: got %h/%h want %h/%h at %0t", instr_addr, instr_out, exp_addr, fdat(exp_addr), $time);
        end
        exp_addr++;
        n_pop++;
      end
      cap = pending && seen_hi && !busy_fl;
      if (cap) begin
        if (!(tainted || br_valid)) begin m_level++; m_pc++; end
        pending = 0;
      end else if (pending && busy_fl) seen_hi = 1;
      if (ld_flash) begin pending = 1; seen_hi = 0; tainted = 0; end
      if (br_valid) begin m_level = 0; exp_addr = br_target; m_pc = br_target; tainted = pending; end
      if (pop) m_level--;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 0; instr_ready = 0; br_valid = 0; br_target = 0;
    tick(3);
    rst = 1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ld_flash) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wait_req: got no ld_flash want one within 100 cycles"); end
  endtask

  task automatic wait_level(input int lv);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (int'(level) == lv) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wait_level: got level %0d want %0d", level, lv); end
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (instr_valid) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wait_valid: got instr_valid 0 want 1"); end
  endtask

  task automatic test_reset();
    rst = 0;
    tick(2);
    n_cmp++;
    if ({ld_flash, level, instr_valid, instr_out, instr_addr, flash_addr_PC} !== {1'b0, 3'd0, 1'b0, 32'd0, 10'd0, RESET_PC}) begin
      n_err++;
      $display("FAIL reset: got ld=%b lvl=%0d v=%b out=%h addr=%h pc=%h want all zero",
               ld_flash, level, instr_valid, instr_out, instr_addr, flash_addr_PC);
    end
    rst = 1;
  endtask

  task automatic test_fill();
    rnd = 0; hi_cfg = 2;
    do_reset();
    reqs.delete();
    tick(40);
    n_cmp++;
    if (reqs.size() != 4) begin n_err++; $display("FAIL fill_count: got %0d requests want 4", reqs.size()); end
    for (int i = 0; i < reqs.size() && i < 4; i++) begin
      n_cmp++;
      if (reqs[i] !== 10'(i)) begin n_err++; $display("FAIL fill_addr: got %h want %h", reqs[i], 10'(i)); end
    end
    n_cmp++;
    if (level !== 3'd4 || instr_addr !== 10'h000 || instr_out !== fdat(10'h000)) begin
      n_err++; $display("FAIL fill_head: got lvl %0d addr %h want 4 / 000", level, instr_addr);
    end
  endtask

  task automatic test_drain();
    int p0 = n_pop;
    instr_ready = 1;
    tick();
    n_cmp++;
    if (ld_flash !== 1'b1 || flash_addr_PC !== 10'h004) begin
      n_err++; $display("FAIL drain_resume: got ld=%b addr=%h want 1 / 004", ld_flash, flash_addr_PC);
    end
    tick(40);
    n_cmp++;
    if (n_pop - p0 < 8) begin n_err++; $display("FAIL drain_pops: got %0d want >= 8", n_pop - p0); end
    instr_ready = 0;
  endtask

  task automatic test_branch_wait_lo();
    bit ok;
    do_reset();
    instr_ready = 1;
    for (int i = 0; i < 10; i++) begin
      wait_req(ok);
      if (!ok || flash_addr_PC == 10'h006) break;
    end
    tick(3);
    br_valid = 1; br_target = 10'h200;
    tick();
    br_valid = 0;
    n_cmp++;
    if (level !== 3'd0) begin n_err++; $display("FAIL br_level: got %0d want 0", level); end
    wait_req(ok);
    n_cmp++;
    if (flash_addr_PC !== 10'h200) begin n_err++; $display("FAIL br_req: got %h want 200", flash_addr_PC); end
    wait_valid();
    n_cmp++;
    if (instr_addr !== 10'h200 || instr_out !== fdat(10'h200)) begin
      n_err++; $display("FAIL br_head: got %h want 200", instr_addr);
    end
    instr_ready = 0;
  endtask

  task automatic test_branch_pop();
    do_reset();
    wait_level(3);
    instr_ready = 1; br_valid = 1; br_target = 10'h100;
    tick();
    br_valid = 0; instr_ready = 0;
    n_cmp++;
    if (level !== 3'd0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL brpop_level: got %0d valid %b want 0 / 0", level, instr_valid);
    end
    instr_ready = 1;
    wait_valid();
    n_cmp++;
    if (instr_addr !== 10'h100) begin n_err++; $display("FAIL brpop_head: got %h want 100", instr_addr); end
    instr_ready = 0;
  endtask

  task automatic test_wrap();
    logic [9:0] wexp[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    do_reset();
    instr_ready = 1;
    tick(2);
    br_valid = 1; br_target = 10'h3FE;
    tick();
    br_valid = 0;
    reqs.delete();
    for (int i = 0; i < 100 && reqs.size() < 4; i++) tick();
    n_cmp++;
    if (reqs.size() < 4) begin n_err++; $display("FAIL wrap_count: got %0d want 4", reqs.size()); end
    for (int i = 0; i < 4 && i < reqs.size(); i++) begin
      n_cmp++;
      if (reqs[i] !== wexp[i]) begin n_err++; $display("FAIL wrap_addr: got %h want %h", reqs[i], wexp[i]); end
    end
    instr_ready = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    hi_cfg = 4;
    do_reset();
    wait_level(2);
    wait_req(ok);
    tick();
    rst = 0;
    #1;
    n_cmp++;
    if (ld_flash !== 1'b0 || level !== 3'd0 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: got ld=%b lvl=%0d v=%b want 0/0/0", ld_flash, level, instr_valid);
    end
    tick();
    rst = 1;
    reqs.delete();
    wait_req(ok);
    n_cmp++;
    if (flash_addr_PC !== RESET_PC) begin n_err++; $display("FAIL rst_req: got %h want %h", flash_addr_PC, RESET_PC); end
    hi_cfg = 2;
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    rnd = 1;
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = $urandom_range(0, 9) < 7;
      br_valid = $urandom_range(0, 49) == 0;
      br_target = 10'($urandom);
      tick();
    end
    br_valid = 0; rnd = 0;
    n_cmp++;
    if (n_pop - p0 < 100) begin n_err++; $display("FAIL random_pops: got %0d want >= 100", n_pop - p0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_branch_wait_lo();
    test_branch_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
